// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared state encoding and default geometry for the pixel readout controller.
package pixel_readout_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STREAM, S_DONE} state_e;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_SETTLE = 2;
  localparam int SETTLE_W   = 4;
endpackage

// File: rtl/readout_row_buffer.sv
// readout_row_buffer: captures one full row from the column buses and selects the current pixel.
module readout_row_buffer
  import pixel_readout_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int DW   = DEF_DW
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     load_i,
  input  logic [COLS*DW-1:0]       data_i,
  input  logic [$clog2(COLS)-1:0]  col_i,
  output logic [DW-1:0]            data_o
);
  logic [COLS*DW-1:0] buf_q;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) buf_q <= '0;
    else if (load_i) buf_q <= data_i;
  assign data_o = buf_q[col_i*DW +: DW];
endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: row-sequential readout of the pixel array, one row select at a time,
// latching each settled row and streaming its pixels over a valid/ready handshake.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DW     = DEF_DW,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [COLS*DW-1:0]       DATA_IN,
  output logic [ROWS-1:0]          READ,
  output logic                     BUSY,
  output logic [DW-1:0]            PIX_DATA,
  output logic [$clog2(ROWS)-1:0]  PIX_ROW,
  output logic [$clog2(COLS)-1:0]  PIX_COL,
  output logic                     PIX_LAST,
  output logic                     PIX_VALID,
  input  logic                     PIX_READY,
  output logic                     FRAME_DONE
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic              load;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (state_q != S_IDLE && ABORT) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          state_d = S_SETTLE;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
        S_SETTLE: if (cnt_q == SETTLE_W'(SETTLE - 1)) begin
          load    = 1'b1;
          state_d = S_STREAM;
          col_d   = '0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        S_STREAM: if (PIX_READY) begin
          if (col_q != CW'(COLS - 1)) col_d = col_q + 1'b1;
          else if (row_q != RW'(ROWS - 1)) begin
            row_d   = row_q + 1'b1;
            state_d = S_SETTLE;
          end else state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // Outputs decode directly from registered state so an async reset releases the bus at once.
  assign READ       = (state_q == S_SETTLE) ? ROWS'(1) << row_q : '0;
  assign BUSY       = state_q != S_IDLE;
  assign PIX_VALID  = state_q == S_STREAM;
  assign PIX_ROW    = row_q;
  assign PIX_COL    = col_q;
  assign PIX_LAST   = PIX_VALID && row_q == RW'(ROWS - 1) && col_q == CW'(COLS - 1);
  assign FRAME_DONE = state_q == S_DONE;
  readout_row_buffer #(.COLS(COLS), .DW(DW)) u_buf (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .load_i  (load),
    .data_i  (DATA_IN),
    .col_i   (col_q),
    .data_o  (PIX_DATA)
  );
endmodule
